reg_bank_sb: RTL
================

Name: reg_bank_sb

Overview:
Parametrised scoreboarded register bank for the ID stage; successor to the fixed 8x16 bank. Provides three synchronous read ports with write-to-read bypass, one write port, and a per-register pending-write scoreboard for hazard detection. Includes an optional hardwired-zero register and a multi-cycle clear sequencer. All logic is on the rising edge of clk.

Parameters:
DATA_W, 16, register width in bits
NREGS, 8, number of registers; power of two, at least 2
ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes and marks
AW, $clog2(NREGS), address width (derived; not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
rd_en  in  1  capture read ports this cycle
rs1_addr, rs2_addr, rs3_addr  in  AW  read addresses
rs1_data, rs2_data, rs3_data  out  DATA_W  registered read data
rs1_busy, rs2_busy, rs3_busy  out  1  registered pending flag of the addressed register
we  in  1  write enable
wr_addr  in  AW  write address
wr_data  in  DATA_W  write data
mark_en  in  1  set pending for mark_addr (instruction issued with this destination)
mark_addr  in  AW  destination being marked
mark_conflict  out  1  one-cycle pulse: marked register was already pending
clr_req  in  1  start the sequential clear
clr_busy  out  1  clear sequence in progress

Behaviour:
- Reset: all registers 0, all pending bits 0, rsN_data 0, rsN_busy 0, mark_conflict 0, clr_busy 0, FSM in IDLE. Reset overrides every other input, including mid-clear.
- Write: in IDLE with we=1, mem[wr_addr] <= wr_data and pending[wr_addr] <= 0.
- Mark: in IDLE with mark_en=1, pending[mark_addr] <= 1. If mark_en and we target the same address in the same cycle, the mark wins (pending ends at 1).
- mark_conflict <= 1 for one cycle when mark_en=1 and pending[mark_addr] was already 1 before the edge. It stays 0 if a same-cycle write to that address clears the old pending bit.
- Read: latency 1. With rd_en=1 in IDLE, rsN_data <= value of the addressed register after this cycle's write. Bypass rule: if we=1 and wr_addr==rsN_addr, the port returns wr_data.
- rsN_busy <= pending bit of rsN_addr after this cycle's write and mark updates.
- With rd_en=0, the data and busy outputs hold their values.
- ZERO_REG=1: writes and marks to address 0 are ignored. Reads of address 0 return data 0 and busy 0, with no bypass. mark_conflict never fires for address 0.
- Clear FSM, states IDLE and CLEAR:
  - IDLE with clr_req=1: go to CLEAR, idx <= 0, clr_busy <= 1.
  - In CLEAR, each cycle: mem[idx] <= 0, pending[idx] <= 0, idx <= idx+1.
  - When idx==NREGS-1, that register is cleared and the FSM returns to IDLE with clr_busy <= 0. Total duration is NREGS cycles.
  - In CLEAR, we, mark_en, rd_en and clr_req are ignored. Read outputs hold; mark_conflict stays 0.
  - clr_req in the same cycle as we or mark_en in IDLE: the write and mark take effect, then CLEAR starts on the next cycle.
- idx is AW bits wide and must not wrap before leaving CLEAR.

Decomposition:
- Shared package regbank_pkg: state enum (IDLE, CLEAR) and default DATA_W/NREGS constants.
- One sub-module, regbank_scoreboard: the pending bit vector, mark/clear/write update logic, and mark_conflict generation. Storage, read ports and the FSM stay in reg_bank_sb.

Test Plan:
- Reset, then write 0x1234 to r5; one cycle later read rs1=r5 -> rs1_data=0x1234, rs1_busy=0.
- Same-cycle we to r3 with 0xBEEF and rd_en with rs2=r3 -> next cycle rs2_data=0xBEEF (bypass).
- mark r4; read r4 -> busy=1. mark r4 again -> mark_conflict pulses 1 for exactly one cycle. Write r4 -> a following read gives busy=0.
- Same-cycle mark and write to r6 -> pending[6]=1 and mark_conflict=0.
- ZERO_REG=1: write 0xFFFF to r0 and mark r0 -> read r0 gives data 0, busy 0, mark_conflict 0.
- Fill all 8 registers with nonzero values and mark r2, then clr_req -> clr_busy high for exactly 8 cycles and writes during it are ignored. Afterwards all reads return 0, busy 0. Repeat with rst asserted at cycle 3 of CLEAR -> clr_busy 0 and all registers 0 on the next cycle.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared types and default sizing for the scoreboarded register bank.
// Latency: n/a (types only). Backpressure: n/a.
package regbank_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_NREGS  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/regbank_scoreboard.sv
// Per-register pending-write bits with write/mark/clear updates and conflict detection.
// Latency: pending and mark_conflict update one cycle after the request. Backpressure: none.
module regbank_scoreboard #(
    parameter int NREGS    = 8,
    parameter int ZERO_REG = 0,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd_en,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic             mark_en,
    input  logic [AW-1:0]    mark_addr,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_idx,
    output logic [NREGS-1:0] pend_nxt,
    output logic             mark_conflict
);

    logic [NREGS-1:0] pending;
    logic             wr_ok;
    logic             mk_ok;
    logic             conflict_nxt;

    assign wr_ok = upd_en && we && !((ZERO_REG != 0) && (wr_addr == '0));
    assign mk_ok = upd_en && mark_en && !((ZERO_REG != 0) && (mark_addr == '0));

    // Mark is applied after the write so a same-cycle mark leaves the bit set.
    always_comb begin
        pend_nxt = pending;
        if (wr_ok) begin
            pend_nxt[wr_addr] = 1'b0;
        end
        if (mk_ok) begin
            pend_nxt[mark_addr] = 1'b1;
        end
        if (clr_en) begin
            pend_nxt[clr_idx] = 1'b0;
        end
    end

    // A same-cycle write retires the old pending bit, so that is not a conflict.
    assign conflict_nxt = mk_ok && pending[mark_addr] && !(wr_ok && (wr_addr == mark_addr));

    always_ff @(posedge clk) begin
        if (rst) begin
            pending       <= '0;
            mark_conflict <= 1'b0;
        end else begin
            pending       <= pend_nxt;
            mark_conflict <= conflict_nxt;
        end
    end

endmodule

// File: rtl/reg_bank_sb.sv
// Register bank: three bypassed read ports, one write port, pending scoreboard, sequential clear.
// Latency: reads/busy 1 cycle; clear takes NREGS cycles. Backpressure: none; inputs ignored while clearing.
module reg_bank_sb
    import regbank_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NREGS    = DEF_NREGS,
    parameter int ZERO_REG = 0,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [AW-1:0]     rs1_addr,
    input  logic [AW-1:0]     rs2_addr,
    input  logic [AW-1:0]     rs3_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [DATA_W-1:0] rs3_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              rs3_busy,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              mark_en,
    input  logic [AW-1:0]     mark_addr,
    output logic              mark_conflict,
    input  logic              clr_req,
    output logic              clr_busy
);

    logic [DATA_W-1:0] mem [NREGS];
    state_e            state, state_nxt;
    logic [AW-1:0]     idx, idx_nxt;
    logic              idle;
    logic              clr_en;
    logic              wr_ok;
    logic [NREGS-1:0]  pend_nxt;

    logic [AW-1:0]     rs_addr [3];
    logic [DATA_W-1:0] rd_nxt  [3];
    logic              bz_nxt  [3];
    logic [DATA_W-1:0] rd_q    [3];
    logic              bz_q    [3];

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign idle   = (state == IDLE);
    assign clr_en = (state == CLEAR);
    assign wr_ok  = idle && we && !is_zero(wr_addr);

    assign rs_addr[0] = rs1_addr;
    assign rs_addr[1] = rs2_addr;
    assign rs_addr[2] = rs3_addr;

    regbank_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_sb (
        .clk           (clk),
        .rst           (rst),
        .upd_en        (idle),
        .we            (we),
        .wr_addr       (wr_addr),
        .mark_en       (mark_en),
        .mark_addr     (mark_addr),
        .clr_en        (clr_en),
        .clr_idx       (idx),
        .pend_nxt      (pend_nxt),
        .mark_conflict (mark_conflict)
    );

    // Read values reflect this cycle's write (bypass) and scoreboard updates.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_nxt[p] = mem[rs_addr[p]];
            bz_nxt[p] = pend_nxt[rs_addr[p]];
            if (wr_ok && (wr_addr == rs_addr[p])) begin
                rd_nxt[p] = wr_data;
            end
            if (is_zero(rs_addr[p])) begin
                rd_nxt[p] = '0;
                bz_nxt[p] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
            for (int p = 0; p < 3; p++) begin
                rd_q[p] <= '0;
                bz_q[p] <= 1'b0;
            end
        end else begin
            if (wr_ok) begin
                mem[wr_addr] <= wr_data;
            end
            if (clr_en) begin
                mem[idx] <= '0;
            end
            if (idle && rd_en) begin
                for (int p = 0; p < 3; p++) begin
                    rd_q[p] <= rd_nxt[p];
                    bz_q[p] <= bz_nxt[p];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // idx wraps only on the same edge that returns to IDLE.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    idx_nxt   = '0;
                end
            end
            CLEAR: begin
                idx_nxt = idx + AW'(1);
                if (idx == AW'(NREGS - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    assign clr_busy = (state == CLEAR);

    assign rs1_data = rd_q[0];
    assign rs2_data = rd_q[1];
    assign rs3_data = rd_q[2];
    assign rs1_busy = bz_q[0];
    assign rs2_busy = bz_q[1];
    assign rs3_busy = bz_q[2];

endmodule
